panda_risc_v_dtcm_ctrl: RTL



---
 rtl/panda_risc_v_dtcm_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/panda_risc_v_dtcm_ctrl.sv
// DTCM controller: ICB load/store to a 1-cycle SRAM, ordered responses via a 3-entry buffer.
// Latency: response 2 cycles after command handshake; cmd_ready is a credit on pending + buffered entries.
module panda_risc_v_dtcm_ctrl #(
  parameter logic [31:0] base_addr        = 32'h1000_0000,
  parameter int          addr_range       = 32768,
  parameter int          simulation_delay = 1
) (
  input  logic                              clk,
  input  logic                              sys_reset,
  input  logic [31:0]                       s_icb_cmd_addr,
  input  logic                              s_icb_cmd_read,
  input  logic [31:0]                       s_icb_cmd_wdata,
  input  logic [3:0]                        s_icb_cmd_wmask,
  input  logic                              s_icb_cmd_valid,
  output logic                              s_icb_cmd_ready,
  output logic [31:0]                       s_icb_rsp_rdata,
  output logic                              s_icb_rsp_err,
  output logic                              s_icb_rsp_valid,
  input  logic                              s_icb_rsp_ready,
  output logic                              bram_en,
  output logic [3:0]                        bram_wen,
  output logic [$clog2(addr_range)-3:0]     bram_addr,
  output logic [31:0]                       bram_din,
  input  logic [31:0]                       bram_dout
);

  localparam int lg = $clog2(addr_range);
  localparam int unused_sim_delay = simulation_delay;

  logic        cmd_hs;
  logic        in_range;
  logic        rsp_pop;
  logic        unused_addr_lsb;

  logic        pend_vld;
  logic        pend_read;
  logic        pend_err;
  logic [31:0] push_rdata;

  logic [31:0] fifo_rdata [0:2];
  logic        fifo_err   [0:2];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [1:0]  cnt;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign unused_addr_lsb = ^s_icb_cmd_addr[1:0];

  assign in_range = (s_icb_cmd_addr[31:lg] == base_addr[31:lg]);
  assign cmd_hs   = s_icb_cmd_valid & s_icb_cmd_ready;
  assign rsp_pop  = s_icb_rsp_valid & s_icb_rsp_ready;

  // Credit counts the in-flight SRAM access too, so a push can never find the buffer full.
  assign s_icb_cmd_ready = ~sys_reset & ((3'({2'b00, pend_vld}) + 3'({1'b0, cnt})) < 3'd3);

  assign bram_en   = cmd_hs & in_range;
  assign bram_wen  = (cmd_hs & in_range & ~s_icb_cmd_read) ? s_icb_cmd_wmask : 4'b0000;
  assign bram_addr = s_icb_cmd_addr[lg-1:2];
  assign bram_din  = s_icb_cmd_wdata;

  assign push_rdata = (pend_read & ~pend_err) ? bram_dout : 32'h0;

  assign s_icb_rsp_valid = (cnt != 2'd0);
  assign s_icb_rsp_rdata = s_icb_rsp_valid ? fifo_rdata[rd_ptr] : 32'h0;
  assign s_icb_rsp_err   = s_icb_rsp_valid ? fifo_err[rd_ptr]   : 1'b0;

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      pend_vld  <= 1'b0;
      pend_read <= 1'b0;
      pend_err  <= 1'b0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      cnt       <= 2'd0;
    end else begin
      pend_vld  <= cmd_hs;
      pend_read <= s_icb_cmd_read;
      pend_err  <= ~in_range;
      if (pend_vld) wr_ptr <= ptr_next(wr_ptr);
      if (rsp_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({pend_vld, rsp_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset: the count gates what is visible at the head.
  always_ff @(posedge clk) begin
    if (pend_vld & ~sys_reset) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_err[wr_ptr]   <= pend_err;
    end
  end

endmodule
